// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its consumers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Key codes follow row*4 + col for the standard 1-2-3-A legend.
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // True when exactly one of the four active-low lines is asserted.
    function automatic logic is_single(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a single-cycle strobe every DIV clocks.
module tick_gen #(
    parameter int DIV = 27000,
    parameter int W   = 15
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, press/release debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 27000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int CNT_W          = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       keypad_pressed,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int             DW      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_TICKS);

    logic          tick;
    logic [3:0]    sync_p0, rows_s;
    state_t        state, state_n;
    logic [3:0]    col_n;
    logic [DW-1:0] dcnt, dcnt_n, dcnt_inc;
    logic [1:0]    row_idx, row_n, col_idx, col_idx_n, hit_row;
    logic          pressed_n, valid_n, single;
    logic [3:0]    code_n, col_rot;

    tick_gen #(.DIV(TICK_DIV), .W(CNT_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Stage p0/p1: two-flop synchronizer on the asynchronous rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 4'hF;
            rows_s  <= 4'hF;
        end else begin
            sync_p0 <= row_in;
            rows_s  <= sync_p0;
        end
    end

    assign single   = is_single(rows_s);
    assign hit_row  = low_index(rows_s);
    assign col_rot  = {col_out[2:0], col_out[3]};
    assign dcnt_inc = dcnt + 1'b1;

    always_comb begin
        state_n   = state;
        col_n     = col_out;
        dcnt_n    = dcnt;
        row_n     = row_idx;
        col_idx_n = col_idx;
        pressed_n = keypad_pressed;
        code_n    = key_code;
        valid_n   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        row_n     = hit_row;
                        col_idx_n = low_index(col_out);
                        dcnt_n    = DW'(1);
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (single && (hit_row == row_idx)) begin
                        if (dcnt_inc == DB_LAST) begin
                            state_n   = HELD;
                            pressed_n = 1'b1;
                            code_n    = {row_idx, col_idx};
                            valid_n   = 1'b1;
                            dcnt_n    = '0;
                        end else begin
                            dcnt_n = dcnt_inc;
                        end
                    end else begin
                        state_n = SCAN;
                        col_n   = col_rot;
                    end
                end
                HELD: begin
                    // Any low row, including a second key, restarts the release count.
                    if (rows_s == 4'hF) begin
                        if (dcnt_inc == DB_LAST) begin
                            state_n   = SCAN;
                            pressed_n = 1'b0;
                            col_n     = col_rot;
                            dcnt_n    = '0;
                        end else begin
                            dcnt_n = dcnt_inc;
                        end
                    end else begin
                        dcnt_n = '0;
                    end
                end
                default: begin
                    state_n = SCAN;
                    dcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SCAN;
            col_out        <= COL_RESET;
            dcnt           <= '0;
            row_idx        <= '0;
            col_idx        <= '0;
            keypad_pressed <= 1'b0;
            key_code       <= '0;
            key_valid      <= 1'b0;
        end else begin
            state          <= state_n;
            col_out        <= col_n;
            dcnt           <= dcnt_n;
            row_idx        <= row_n;
            col_idx        <= col_idx_n;
            keypad_pressed <= pressed_n;
            key_code       <= code_n;
            key_valid      <= valid_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner against a tick-level keypad model.
module tb_keypad_scanner;

    localparam int TICK_DIV = 10;
    localparam int DT       = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        keypad_pressed;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys = '0;

    int total = 0;
    int bad   = 0;
    int vcount = 0;
    logic saw_press = 1'b0;

    // Reference model state (integers, tick-level behaviour).
    int   m_cnt, m_col, m_mode, m_streak, m_row, m_lcol, m_code;
    logic m_pressed, m_valid;
    logic [3:0] m_sync, m_rows;

    keypad_scanner #(.TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .row_in         (row_in),
        .col_out        (col_out),
        .keypad_pressed (keypad_pressed),
        .key_code       (key_code),
        .key_valid      (key_valid)
    );

    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a closed key sits on a driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [3:0] raw;
        int nlow, idx;
        raw = 4'hF;
        for (int r = 0; r < 4; r++)
            if (keys[r*4+m_col]) raw[r] = 1'b0;
        if (rst) begin
            m_cnt = 0; m_col = 0; m_mode = 0; m_streak = 0; m_row = 0; m_lcol = 0;
            m_code = 0; m_pressed = 0; m_valid = 0; m_sync = 4'hF; m_rows = 4'hF;
        end else begin
            m_valid = 0;
            if (m_cnt == TICK_DIV - 1) begin
                nlow = 0; idx = 0;
                for (int r = 0; r < 4; r++)
                    if (!m_rows[r]) begin nlow++; idx = r; end
                if (m_mode == 0) begin
                    if (nlow == 1) begin
                        m_row = idx; m_lcol = m_col; m_streak = 1; m_mode = 1;
                    end else m_col = (m_col + 1) % 4;
                end else if (m_mode == 1) begin
                    if (nlow == 1 && idx == m_row) begin
                        m_streak++;
                        if (m_streak == DT) begin
                            m_mode = 2; m_pressed = 1; m_valid = 1; m_streak = 0;
                            m_code = m_row * 4 + m_lcol;
                        end
                    end else begin
                        m_mode = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    if (nlow == 0) begin
                        m_streak++;
                        if (m_streak == DT) begin
                            m_mode = 0; m_pressed = 0; m_streak = 0; m_col = (m_col + 1) % 4;
                        end
                    end else m_streak = 0;
                end
            end
            m_cnt = (m_cnt + 1) % TICK_DIV;
            m_rows = m_sync;
            m_sync = raw;
        end
    endtask

    task automatic step();
        logic [3:0] one;
        logic [9:0] expv;
        @(posedge clk);
        #1;
        model_edge();
        one  = 4'b0001 << m_col;
        expv = {~one, m_pressed, 4'(m_code), m_valid};
        chk("cycle", 16'({col_out, keypad_pressed, key_code, key_valid}), 16'(expv));
        if (key_valid) vcount++;
        if (keypad_pressed) saw_press = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pressed(input logic level, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (keypad_pressed == level) break;
            step();
        end
        chk("wait_pressed", 16'(keypad_pressed), 16'(level));
    endtask

    initial begin
        rst = 1'b1;
        run(2);
        chk("reset_col", 16'(col_out), 16'hE);
        chk("reset_pressed", 16'({keypad_pressed, key_valid}), 16'h0);
        chk("reset_code", 16'(key_code), 16'h0);
        rst = 1'b0;
        run(4 * TICK_DIV);
        chk("col_cycle", 16'(col_out), 16'hE);
        chk("idle_no_press", 16'({saw_press, 4'(vcount)}), 16'h0);

        // Single key (2,1)
        vcount = 0;
        keys = 16'(1) << 9;
        wait_pressed(1'b1, 300);
        run(20);
        chk("held_code", 16'(key_code), 16'd9);
        chk("held_col", 16'(col_out), 16'hD);
        chk("held_valid_once", 16'(vcount), 16'd1);

        keys = '0;
        wait_pressed(1'b0, 300);
        chk("release_col", 16'(col_out), 16'hB);
        chk("release_code", 16'(key_code), 16'd9);

        // Bounce: one tick closed, one tick open
        vcount = 0; saw_press = 1'b0;
        for (int i = 0; i < 30; i++) begin
            keys = (i % 2 == 0) ? (16'(1) << 9) : 16'h0;
            run(TICK_DIV);
        end
        keys = '0;
        run(2 * TICK_DIV);
        chk("bounce_no_press", 16'({saw_press, 4'(vcount)}), 16'h0);

        // Ghosting on column 3, then resolve to (0,3)
        vcount = 0; saw_press = 1'b0;
        keys = (16'(1) << 3) | (16'(1) << 7);
        run(20 * TICK_DIV);
        chk("ghost_no_press", 16'({saw_press, 4'(vcount)}), 16'h0);
        keys = 16'(1) << 3;
        wait_pressed(1'b1, 300);
        chk("ghost_resolved_code", 16'(key_code), 16'd3);
        keys = '0;
        wait_pressed(1'b0, 300);

        // Reset while held on (3,3)
        keys = 16'(1) << 15;
        wait_pressed(1'b1, 300);
        run(5);
        rst = 1'b1;
        step();
        chk("midrst_pressed", 16'(keypad_pressed), 16'h0);
        chk("midrst_col", 16'(col_out), 16'hE);
        rst = 1'b0;
        vcount = 0;
        wait_pressed(1'b1, 400);
        chk("reaccept_code", 16'(key_code), 16'd15);
        run(30);
        chk("reaccept_valid_once", 16'(vcount), 16'd1);
        keys = '0;
        wait_pressed(1'b0, 300);

        // Randomized presses, ghosts, bounces and resets
        for (int it = 0; it < 40; it++) begin
            keys = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) keys = keys | (16'(1) << $urandom_range(0, 15));
            run($urandom_range(1, 10) * TICK_DIV + $urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            keys = '0;
            run($urandom_range(1, 6) * TICK_DIV + $urandom_range(0, 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces press and release, and produces the `keypad_pressed` level plus the key code consumed by the sound and game-control blocks.
- Drives one column low at a time, samples the rows through a synchronizer, and locks onto a single debounced key.
- `keypad_pressed` stays high for as long as the key is held, and always for at least one scan tick, so slower consumers (1 kHz domain) see every press.

Parameters:
- TICK_DIV, 27000: clk cycles per scan tick (1 ms at 27 MHz); must be ≥ 2.
- DEBOUNCE_TICKS, 20: consecutive identical ticks required to accept a press or a release; must be ≥ 2.
- CNT_W, 15: width of the tick divider counter; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- row_in, input, 4: keypad rows, active-low with pull-ups, asynchronous.
- col_out, output, 4: column drive, active-low, exactly one bit low at any time.
- keypad_pressed, output, 1: debounced level, high while a valid key is held.
- key_code, output, 4: `row*4 + col` of the last accepted key; holds its value after release.
- key_valid, output, 1: one-clk strobe when a new press is accepted.

Behaviour:
- Reset values (applied at the first clk edge with rst=1):
  - col_out = 4'b1110, keypad_pressed = 0, key_code = 0, key_valid = 0.
  - State = SCAN, tick counter = 0, debounce counter = 0, synchronizer flops = 4'hF.
- A mid-operation reset returns to these values on the next edge, including dropping keypad_pressed.
- Synchronizer: two-flop on row_in. All decisions use the second stage (`rows_s`). Input-to-decision latency is 2 clk.
- Tick: tick counter counts 0..TICK_DIV-1 and wraps. `tick` is high for the single cycle when the count equals TICK_DIV-1. All state changes happen only on tick cycles, except the key_valid clear.
- "Single key": exactly one bit of rows_s is 0. Two or more low rows are ghosting and are treated as no key.
- SCAN:
  - On tick with a single key: latch row and column index, set debounce counter = 1, go to DEBOUNCE. The column is frozen.
  - On tick otherwise: rotate col_out left by one (1110 → 1101 → 1011 → 0111 → 1110).
- DEBOUNCE:
  - On tick with the same single row low: increment the counter.
  - When the counter reaches DEBOUNCE_TICKS: go to HELD, set keypad_pressed = 1, load key_code, and pulse key_valid for exactly one clk.
  - On tick with anything else: go to SCAN and advance the column. No outputs change.
- HELD:
  - On tick with all rows high: increment the release counter.
  - On tick with any row low: clear the release counter.
  - When the release counter reaches DEBOUNCE_TICKS: keypad_pressed = 0, go to SCAN, and advance the column.
- Press latency: with a key stable from before the first detecting tick T0, keypad_pressed and key_valid rise on the clk after tick T0+DEBOUNCE_TICKS-1.
- Release latency: keypad_pressed falls on the clk after the DEBOUNCE_TICKS-th consecutive all-high tick.
- key_valid never asserts twice for one press. A new press requires a full release first.
- A second key pressed while in HELD is ignored. Release completes only once all rows are high.
- col_out does not change in DEBOUNCE or HELD.

Decomposition:
- Package `keypad_pkg`:
  - State localparams SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2.
  - NUM_ROWS=4, NUM_COLS=4.
  - Key-code constants for the keypad legend (KEY_1=4'd0 … KEY_D=4'd15).
  - COL_RESET=4'b1110.
- Sub-module `tick_gen`:
  - Parameters DIV and W; ports clk, rst, tick.
  - Single-cycle strobe every DIV cycles.
  - Reusable by other blocks that need a 1 kHz strobe.

Test Plan (TICK_DIV=10, DEBOUNCE_TICKS=3, keypad model: row r reads 0 iff key (r,c) is closed and col_out[c]=0):
- Reset, no keys pressed → col_out = 1110; after 4 ticks it has cycled through 1101, 1011, 0111 and back to 1110; keypad_pressed = 0 and key_valid = 0 throughout.
- Close key (row 2, col 1) and hold → detected when col_out = 1101; keypad_pressed rises 2 ticks after the detecting tick (+1 clk); key_code = 4'd9; key_valid high for exactly 1 clk; col_out stays 1101.
- Press key (row 2, col 1) as above, then open it → keypad_pressed falls 1 clk after the 3rd all-high tick; key_code stays 9; scanning resumes from 1011.
- Bounce: key closed for 1 tick, open for 1 tick, repeated → keypad_pressed never rises; key_valid stays 0.
- Keys (0,3) and (1,3) closed together → no press accepted. Then release (1,3) → press accepted with key_code = 4'd3.
- rst asserted while in HELD with key (3,3) held → next edge gives keypad_pressed = 0, col_out = 1110. After rst deasserts, key (3,3) is still held → it is re-accepted with key_code = 4'd15 and one key_valid pulse.
